// File: rtl/or_mask_decoder.sv
// Merges two request masks with a bitwise OR, then emits the set bit positions lowest-first over a valid/ready handshake.
// Optional macro OR_MASK_DECODER_COUNT_EN adds count_o, the popcount of the accepted mask.
module or_mask_decoder #(
    parameter int BITS = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [BITS-1:0]           bus_a_i,
    input  logic [BITS-1:0]           bus_b_i,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    output logic [$clog2(BITS)-1:0]   index_o,
    output logic [BITS-1:0]           onehot_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      last_o,
    output logic                      zero_o
`ifdef OR_MASK_DECODER_COUNT_EN
    ,
    output logic [$clog2(BITS+1)-1:0] count_o
`endif
);

    localparam int IW = $clog2(BITS);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_reg;
    logic [BITS-1:0]   mask_reg;
    logic              zero_reg;
    logic [BITS-1:0]   load_mask;
    logic [BITS-1:0]   onehot_c;
    logic [BITS:0]     seen_c;
    logic [IW-1:0]     index_c;
    logic              single_c;

    assign load_mask = bus_a_i | bus_b_i;

    // seen_c[k] is set when any bit below position k is set; the lowest set bit is the one not yet seen.
    assign seen_c[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < BITS; gi++) begin : g_lowest
            assign seen_c[gi+1] = seen_c[gi] | mask_reg[gi];
            assign onehot_c[gi] = mask_reg[gi] & ~seen_c[gi];
        end
    endgenerate

    always_comb begin
        index_c = '0;
        for (int i = 0; i < BITS; i++) begin
            if (onehot_c[i]) begin
                index_c = index_c | IW'(i);
            end
        end
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign single_c = seen_c[BITS] && ((mask_reg & (mask_reg - BITS'(1))) == '0);

    assign load_ready_o = (state_reg == IDLE);
    assign valid_o      = (state_reg == EMIT);
    assign index_o      = index_c;
    assign onehot_o     = onehot_c;
    assign last_o       = valid_o && single_c;
    assign zero_o       = zero_reg;

`ifdef OR_MASK_DECODER_COUNT_EN
    logic [$clog2(BITS+1)-1:0] count_reg;
    logic [$clog2(BITS+1)-1:0] pop_next;

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < BITS; i++) begin
            pop_next = pop_next + ($clog2(BITS+1))'(load_mask[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (state_reg == IDLE && load_valid_i) begin
            count_reg <= pop_next;
        end
    end

    assign count_o = count_reg;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            mask_reg  <= '0;
            zero_reg  <= 1'b0;
        end else begin
            zero_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load_valid_i) begin
                        mask_reg <= load_mask;
                        if (load_mask != '0) begin
                            state_reg <= EMIT;
                        end else begin
                            zero_reg <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (ready_i) begin
                        mask_reg <= mask_reg & ~onehot_c;
                        if (single_c) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
